// File: rtl/alu_seq_ctrl_if.sv
// Handshake and ALU-side bundle for alu_seq_ctrl: request in, registered
// operands out to the ALU, ALU result back, captured result out.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_inst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_inst;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_n;
  logic             alu_v;
  logic             alu_cmp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_z;
  logic             out_n;
  logic             out_v;
  logic             out_cmp;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_inst,
    output alu_out, alu_z, alu_n, alu_v, alu_cmp, out_ready,
    input  in_ready, alu_a, alu_b, alu_inst,
    input  out_valid, out_result, out_z, out_n, out_v, out_cmp, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_inst,
    input  alu_out, alu_z, alu_n, alu_v, alu_cmp, out_ready,
    output in_ready, alu_a, alu_b, alu_inst,
    output out_valid, out_result, out_z, out_n, out_v, out_cmp, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: holds operands on the ALU for one cycle (ordinary)
// or MUL_LATENCY cycles (M-extension multiply), then captures and presents the result.
module alu_seq_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] alu_inst_q, alu_inst_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             cmp_q, cmp_d;

  logic is_mul_s;
  logic in_ready_s;
  logic accept_s;
  logic capture_s;

  // Decode, handshake and capture qualifiers
  always_comb begin
    is_mul_s   = (bus.in_inst[6:0] == 7'b0110011) && (bus.in_inst[31:25] == 7'b0000001);
    in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    capture_s  = (state_q == EXEC) || ((state_q == MUL) && (cnt_q == 4'd0));
  end

  // Next-state, multiply countdown and datapath register loads
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = accept_s  ? bus.in_a    : alu_a_q;
    alu_b_d    = accept_s  ? bus.in_b    : alu_b_q;
    alu_inst_d = accept_s  ? bus.in_inst : alu_inst_q;
    res_d      = capture_s ? bus.alu_out : res_q;
    z_d        = capture_s ? bus.alu_z   : z_q;
    n_d        = capture_s ? bus.alu_n   : n_q;
    v_d        = capture_s ? bus.alu_v   : v_q;
    cmp_d      = capture_s ? bus.alu_cmp : cmp_q;
    case (state_q)
      IDLE: state_d = accept_s ? (is_mul_s ? MUL : EXEC) : IDLE;
      EXEC: state_d = DONE;
      MUL: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = accept_s ? (is_mul_s ? MUL : EXEC) : IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The countdown restarts on every accept, whichever state it occurs in.
    if (accept_s) begin
      cnt_d = CNT_INIT;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
      res_q      <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      cmp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_inst_q <= alu_inst_d;
      res_q      <= res_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      cmp_q      <= cmp_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_inst   = alu_inst_q;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;
  assign bus.out_z      = z_q;
  assign bus.out_n      = n_q;
  assign bus.out_v      = v_q;
  assign bus.out_cmp    = cmp_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU plus a latency/result
// reference derived from the instruction encoding, directed and random steps.
module tb_alu_seq_ctrl;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.WIDTH(W)) bus_if ();
  alu_seq_ctrl #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] cur_a, cur_b, cur_inst, last_res;
  logic [35:0] exp_v;
  logic        last_z;
  int          exp_lat;

  // RV32IM subset: returns {cmp, v, n, z, result}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] inst);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] bb, r;
    logic [63:0] p;
    logic        v, sub, cmp;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    bb  = (opc == 7'h13) ? {{20{inst[31]}}, inst[31:20]} : b;
    sub = (opc == 7'h33) && (f7 == 7'h20) && (f3 == 3'd0);
    v   = 1'b0;
    r   = 32'd0;
    if (opc == 7'h33 && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
        3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
        3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
        default: r = a ^ b;
      endcase
    end else begin
      case (f3)
        3'd0: begin
          r = sub ? a - bb : a + bb;
          v = sub ? ((a[31] != bb[31]) && (r[31] != a[31]))
                  : ((a[31] == bb[31]) && (r[31] != a[31]));
        end
        3'd1: r = a << bb[4:0];
        3'd2: r = {31'd0, $signed(a) < $signed(bb)};
        3'd3: r = {31'd0, a < bb};
        3'd4: r = a ^ bb;
        3'd5: r = f7[5] ? 32'($signed(a) >>> bb[4:0]) : a >> bb[4:0];
        3'd6: r = a | bb;
        default: r = a & bb;
      endcase
    end
    cmp = $signed(a) < $signed(bb);
    return {cmp, v, r[31], (r == 32'd0), r};
  endfunction

  function automatic bit is_mul(input logic [31:0] inst);
    return (inst[6:0] == 7'h33) && (inst[31:25] == 7'h01);
  endfunction

  logic [35:0] alu_s;
  always_comb alu_s = alu_fn(bus_if.alu_a, bus_if.alu_b, bus_if.alu_inst);
  assign bus_if.alu_out = alu_s[31:0];
  assign bus_if.alu_z   = alu_s[32];
  assign bus_if.alu_n   = alu_s[33];
  assign bus_if.alu_v   = alu_s[34];
  assign bus_if.alu_cmp = alu_s[35];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for the coming edge and record what it should produce
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst);
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_inst  = inst;
    cur_a = a; cur_b = b; cur_inst = inst;
    exp_v   = alu_fn(a, b, inst);
    exp_lat = is_mul(inst) ? LAT + 1 : 2;
  endtask

  // Called in cycle T+1 after accept; runs through DONE and the hold cycles
  task automatic wait_done(input int hold, input bit pend, input logic [31:0] pa,
                           input logic [31:0] pinst);
    int lat = 1;
    int busy_cnt = 0;
    chk("alu_a", bus_if.alu_a, cur_a);
    chk("alu_b", bus_if.alu_b, cur_b);
    chk("alu_inst", bus_if.alu_inst, cur_inst);
    while (!bus_if.out_valid && lat < 40) begin
      if (bus_if.busy) busy_cnt++;
      if (bus_if.in_ready) chk("in_ready_exec", bus_if.in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", bus_if.out_result, exp_v[31:0]);
    chk("flags", {bus_if.out_cmp, bus_if.out_v, bus_if.out_n, bus_if.out_z}, exp_v[35:32]);
    last_res = bus_if.out_result;
    last_z   = bus_if.out_z;
    if (bus_if.busy) busy_cnt++;
    for (int h = 0; h < hold; h++) begin
      bus_if.in_valid = pend;
      bus_if.in_a     = pa;
      bus_if.in_inst  = pinst;
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
      chk("hold_valid", bus_if.out_valid, 1'b1);
      chk("hold_result", bus_if.out_result, exp_v[31:0]);
      chk("hold_in_ready", bus_if.in_ready, 1'b0);
      chk("hold_alu_a", bus_if.alu_a, cur_a);
    end
    chk("busy_cycles", busy_cnt, exp_lat + hold);
  endtask

  task automatic consume();
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk("consumed_valid", bus_if.out_valid, 1'b0);
    chk("consumed_busy", bus_if.busy, 1'b0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst,
                        input int hold);
    chk("idle_in_ready", bus_if.in_ready, 1'b1);
    issue(a, b, inst);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    wait_done(hold, 1'b1, $urandom, 32'h0000_0033);
    consume();
  endtask

  logic [31:0] ord_tbl [12] = '{32'h0000_0033, 32'h4000_0033, 32'h0000_1033, 32'h0000_2033,
                                32'h0000_3033, 32'h0000_4033, 32'h0000_5033, 32'h4000_5033,
                                32'h0000_6033, 32'h0000_7033, 32'h0200_0013, 32'h0200_003B};
  logic [31:0] mul_tbl [5]  = '{32'h0200_0033, 32'h0200_1033, 32'h0200_2033,
                                32'h0200_3033, 32'h0200_4033};
  logic [31:0] q_res [$];

  initial begin
    int acc;
    int budget;
    logic [31:0] ri;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = 32'd0;
    bus_if.in_b      = 32'd0;
    bus_if.in_inst   = 32'd0;
    bus_if.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus_if.out_valid, 1'b0);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_in_ready", bus_if.in_ready, 1'b1);
    chk("rst_alu_a", bus_if.alu_a, 32'd0);
    chk("rst_out_result", bus_if.out_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    run_op(32'd5, 32'd7, 32'h0000_0033, 0);
    chk("add_12", last_res, 32'd12);
    chk("add_z", last_z, 1'b0);
    run_op(32'h1234, 32'h1234, 32'h4000_0033, 0);
    chk("sub_0", last_res, 32'd0);
    chk("sub_z", last_z, 1'b1);
    run_op(32'h0001_0001, 32'h0001_0001, 32'h0200_0033, 0);
    chk("mul", last_res, 32'h0002_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0200_3033, 0);
    chk("mulhu", last_res, 32'hFFFF_FFFE);

    // Backpressure with a pending ADDI accepted as out_ready rises
    issue(32'd9, 32'd3, 32'h0000_0033);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    wait_done(5, 1'b1, 32'd1, 32'hFFF0_0013);
    chk("bp_result", last_res, 32'd12);
    bus_if.out_ready = 1'b1;
    issue(32'd1, 32'h5555_AAAA, 32'hFFF0_0013);
    #1;
    chk("bp_in_ready", bus_if.in_ready, 1'b1);
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    wait_done(0, 1'b0, 32'd0, 32'd0);
    chk("addi_0", last_res, 32'd0);
    consume();

    // Randomised mix of ordinary and multiply ops with random backpressure
    for (int i = 0; i < 30; i++) begin
      ri = ($urandom_range(0, 2) == 0) ? mul_tbl[$urandom_range(0, 4)]
                                       : ord_tbl[$urandom_range(0, 11)];
      run_op($urandom, $urandom, ri, $urandom_range(0, 3));
    end

    // Throughput with out_ready high: one ordinary op every 2 cycles
    acc = 0;
    bus_if.out_ready = 1'b1;
    issue($urandom, $urandom, ord_tbl[$urandom_range(0, 11)]);
    for (int c = 0; c < 16; c++) begin
      if (bus_if.in_ready) begin q_res.push_back(exp_v[31:0]); acc++; end
      if (bus_if.out_valid) chk("tp_result", bus_if.out_result, q_res.pop_front());
      @(negedge clk);
      if (bus_if.in_ready === 1'b0 && bus_if.busy)
        issue($urandom, $urandom, ord_tbl[$urandom_range(0, 11)]);
    end
    chk("tp_accepts", acc, 8);
    bus_if.in_valid = 1'b0;
    budget = 0;
    while (q_res.size() != 0 && budget < 10) begin
      if (bus_if.out_valid) chk("tp_drain", bus_if.out_result, q_res.pop_front());
      @(negedge clk);
      budget++;
    end
    chk("tp_drained", q_res.size(), 0);
    bus_if.out_ready = 1'b0;
    @(negedge clk);

    // Reset during the second multiply cycle
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0200_3033, 0);
    issue(32'd3, 32'd4, 32'h0200_0033);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmul_valid", bus_if.out_valid, 1'b0);
    chk("rstmul_result", bus_if.out_result, 32'd0);
    chk("rstmul_busy", bus_if.busy, 1'b0);
    chk("rstmul_alu_a", bus_if.alu_a, 32'd0);
    chk("rstmul_in_ready", bus_if.in_ready, 1'b1);
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.out_valid) acc++;
    end
    chk("rstmul_no_result", acc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
